// File: rtl/datapath_issue_ctrl.sv
// Issue/collect front-end for a fixed-latency arithmetic datapath.
// Commands are registered onto dp_* and tracked through a PIPE-deep valid shift
// register. Each result is captured into a small FIFO and returned on a
// valid/ready stream. The datapath cannot stall, so a command is accepted only
// while an outstanding op's FIFO slot is guaranteed to be free.
module datapath_issue_ctrl #(
  parameter int N          = 16,
  parameter int PIPE       = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [2:0]   in_opcode,
  output logic [N-1:0] dp_a,
  output logic [N-1:0] dp_b,
  output logic [2:0]   dp_opcode,
  input  logic [N-1:0] dp_y,
  input  logic         dp_co,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y,
  output logic         out_co,
  output logic         busy,
  output logic         err_ovf
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);

  logic [PIPE-1:0] vld_sr;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   fifo_count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [N-1:0]    mem_y  [FIFO_DEPTH];
  logic            mem_co [FIFO_DEPTH];

  logic [CW:0] credit_used;
  logic        accept;
  logic        capture;
  logic        full;
  logic        pop;
  logic        wr_en;

  // Credit is taken from registered state only; a pop in the same cycle is not
  // counted, which keeps out_ready off the in_ready path.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign in_ready    = credit_used < DEPTH_SUM;
  assign accept      = in_valid & in_ready;

  // The top bit of the shift register flags the op whose result is on dp_y now.
  assign capture   = vld_sr[PIPE-1];
  assign full      = fifo_count == DEPTH_CNT;
  assign out_valid = fifo_count != '0;
  assign pop       = out_valid & out_ready;
  assign wr_en     = capture & (~full | pop);

  assign busy   = (inflight != '0) | (fifo_count != '0);
  assign out_y  = out_valid ? mem_y[rd_ptr]  : '0;
  assign out_co = out_valid ? mem_co[rd_ptr] : 1'b0;

  // Operand registers toward the datapath; they hold when nothing is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a      <= '0;
      dp_b      <= '0;
      dp_opcode <= '0;
    end else if (accept) begin
      dp_a      <= in_a;
      dp_b      <= in_b;
      dp_opcode <= in_opcode;
    end
  end

  // In-flight tracking: valid shift register and outstanding-op counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr   <= '0;
      inflight <= '0;
    end else begin
      vld_sr[0] <= accept;
      for (int i = 1; i < PIPE; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
      inflight <= inflight + CW'(accept) - CW'(capture);
    end
  end

  // FIFO control: pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      err_ovf    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      fifo_count <= fifo_count + CW'(wr_en) - CW'(pop);
      if (capture & full & ~pop) begin
        err_ovf <= 1'b1;
      end
    end
  end

  // Result storage; contents need no reset because out_valid gates the head.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_y[wr_ptr]  <= dp_y;
      mem_co[wr_ptr] <= dp_co;
    end
  end

endmodule

// File: tb/tb_datapath_issue_ctrl.sv
// Directed bench for datapath_issue_ctrl (N=16, PIPE=2, FIFO_DEPTH=4) with a
// behavioural datapath: dp_* registered by the DUT at edge t, one internal stage
// at t+1, so the result is on dp_y during the cycle ending at edge t+2.
module tb_datapath_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_opcode;
  logic [15:0] dp_a;
  logic [15:0] dp_b;
  logic [2:0]  dp_opcode;
  logic [15:0] dp_y;
  logic        dp_co;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic        out_co;
  logic        busy;
  logic        err_ovf;

  int n_cmp = 0;
  int n_err = 0;

  datapath_issue_ctrl #(.N(16), .PIPE(2), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_opcode (in_opcode),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_opcode (dp_opcode),
    .dp_y      (dp_y),
    .dp_co     (dp_co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_co    (out_co),
    .busy      (busy),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  // Golden arithmetic: {co, y}.
  function automatic logic [16:0] dp_fn(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} + {1'b0, ~b} + 17'd1;
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, a};
      3'd6:    return {1'b0, b};
      default: return {1'b0, ~a};
    endcase
  endfunction

  // One internal pipeline stage of the behavioural datapath.
  logic [16:0] dp_res = '0;
  always_ff @(posedge clk) dp_res <= dp_fn(dp_a, dp_b, dp_opcode);
  assign dp_y  = dp_res[15:0];
  assign dp_co = dp_res[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_opcode = op;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [16:0] exp_q[$];
    logic [16:0] e;
    int issued;
    int cyc;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_err_ovf",   32'(err_ovf),   32'd0);
    chk("rst_dp_a",      32'(dp_a),      32'd0);
    chk("rst_out_y",     32'(out_y),     32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single op 5+3.
    cmd(16'd5, 16'd3, 3'd0); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_dp_a",      32'(dp_a),      32'd5);
    chk("single_dp_b",      32'(dp_b),      32'd3);
    chk("single_dp_op",     32'(dp_opcode), 32'd0);
    chk("single_busy",      32'(busy),      32'd1);
    chk("single_early_ov",  32'(out_valid), 32'd0);
    tick();
    chk("single_t1_ov",     32'(out_valid), 32'd0);
    tick();
    chk("single_t2_ov",     32'(out_valid), 32'd1);
    chk("single_y",         32'(out_y),     32'd8);
    chk("single_co",        32'(out_co),    32'd0);
    tick();
    chk("single_popped_ov", 32'(out_valid), 32'd0);
    chk("single_idle_busy", 32'(busy),      32'd0);

    // Burst of four with the consumer stalled.
    out_ready = 1'b0;
    chk("burst_ready0", 32'(in_ready), 32'd1);
    cmd(16'd10, 16'd20, 3'd0);         tick();
    cmd(16'd100, 16'd1, 3'd1);         tick();
    cmd(16'h00F0, 16'h0FF0, 3'd2);     tick();
    cmd(16'h1234, 16'h00FF, 3'd4);     tick();
    chk("burst_full_ready", 32'(in_ready), 32'd0);
    chk("burst_dp_a4",      32'(dp_a),     32'h1234);
    cmd(16'd7, 16'd7, 3'd0);
    tick(); tick(); tick();
    chk("burst_hold_dp_a",  32'(dp_a),      32'h1234);
    chk("burst_hold_ready", 32'(in_ready),  32'd0);
    chk("burst_ov",         32'(out_valid), 32'd1);
    chk("burst_head_y",     32'(out_y),     32'd30);
    chk("burst_err",        32'(err_ovf),   32'd0);
    in_valid = 1'b0;

    // Drain one, then stall, then drain the rest.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_ready_back", 32'(in_ready), 32'd1);
    chk("drain_y1",         32'(out_y),    32'd99);
    chk("drain_co1",        32'(out_co),   32'd1);
    tick();
    chk("drain_stall_y",    32'(out_y),     32'd99);
    chk("drain_stall_ov",   32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("drain_y2",  32'(out_y),  32'h00F0);
    chk("drain_co2", 32'(out_co), 32'd0);
    tick();
    chk("drain_y3",  32'(out_y),  32'h12CB);
    tick();
    chk("drain_empty_ov",   32'(out_valid), 32'd0);
    chk("drain_empty_busy", 32'(busy),      32'd0);
    out_ready = 1'b0;

    // Capture and pop on the same edge with two entries queued.
    cmd(16'd1, 16'd2, 3'd0);          tick();
    cmd(16'hFFFF, 16'd1, 3'd0);       tick();
    cmd(16'h00FF, 16'h0F0F, 3'd3);    tick();
    in_valid = 1'b0;
    tick();
    chk("simul_head_a", 32'(out_y), 32'd3);
    out_ready = 1'b1;
    tick();
    chk("simul_head_b",  32'(out_y),     32'd0);
    chk("simul_co_b",    32'(out_co),    32'd1);
    chk("simul_ov",      32'(out_valid), 32'd1);
    tick();
    chk("simul_head_c",  32'(out_y),     32'h0FFF);
    tick();
    chk("simul_empty",   32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Random traffic against the golden model, in issue order.
    issued = 0;
    cyc    = 0;
    while ((issued < 200 || exp_q.size() != 0 || busy) && cyc < 5000) begin
      in_valid  = (issued < 200) && ($urandom_range(0, 3) != 0);
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_opcode = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(dp_fn(in_a, in_b, in_opcode));
        issued++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_result", 32'({out_co, out_y}), 32'(e));
        end
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rnd_in_time",  32'(cyc < 5000),    32'd1);
    chk("rnd_issued",   32'(issued),        32'd200);
    chk("rnd_leftover", 32'(exp_q.size()),  32'd0);
    chk("rnd_err",      32'(err_ovf),       32'd0);

    // Reset with two queued and two in flight.
    cmd(16'd9, 16'd9, 3'd0); tick(); tick(); tick(); tick();
    in_valid = 1'b0;
    chk("mid_busy_pre", 32'(busy),      32'd1);
    chk("mid_ov_pre",   32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ov",   32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy),      32'd0);
    chk("mid_rst_dp_a", 32'(dp_a),      32'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_no_stale_ov", 32'(out_valid), 32'd0);
    chk("mid_idle_busy",   32'(busy),      32'd0);
    cmd(16'd3, 16'd4, 3'd0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("mid_fresh_ov", 32'(out_valid), 32'd1);
    chk("mid_fresh_y",  32'(out_y),     32'd7);
    out_ready = 1'b1;
    tick();
    chk("mid_fresh_pop", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
